// File: rtl/reset_sequencer.sv
// Staged reset sequencer: holds four stage resets, releases them one at a time
// once each previous stage reports ready, and latches a fault on timeout or loss of ready.
module reset_sequencer #(
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic       CLK_IN,
  input  logic       RESET_IN,
  input  logic       SOFT_RESET_IN,
  input  logic [3:0] STAGE_READY_IN,
  output logic [3:0] STAGE_RESET_OUT,
  output logic       ALL_READY_OUT,
  output logic       FAULT_OUT,
  output logic [1:0] FAULT_STAGE_OUT,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    S_HOLD    = 3'd0,
    S_RELEASE = 3'd1,
    S_WAIT    = 3'd2,
    S_GAP     = 3'd3,
    S_DONE    = 3'd4,
    S_FAULT   = 3'd5
  } state_e;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

  // Internal reset asserts with RESET_IN and releases two clock edges after it rises.
  logic [1:0] sync_q;
  logic       rst_int_n;

  always_ff @(posedge CLK_IN or negedge RESET_IN) begin
    if (!RESET_IN) sync_q <= 2'b00;
    else           sync_q <= {sync_q[0], 1'b1};
  end

  assign rst_int_n = sync_q[1];

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] stage_rst_q, stage_rst_d;
  logic       all_ready_q, all_ready_d;
  logic       fault_q, fault_d;
  logic [1:0] fault_stage_q, fault_stage_d;
  logic [1:0] low_idx;

  always_comb begin
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!STAGE_READY_IN[i]) low_idx = 2'(i);
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    stage_rst_d   = stage_rst_q;
    all_ready_d   = all_ready_q;
    fault_d       = fault_q;
    fault_stage_d = fault_stage_q;

    case (state_q)
      S_HOLD: begin
        stage_rst_d = 4'hF;
        if (cnt_q == HOLD_LAST) begin
          state_d = S_RELEASE;
          idx_d   = 2'd0;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RELEASE: begin
        stage_rst_d[idx_q] = 1'b0;
        state_d            = S_WAIT;
        cnt_d              = 8'd0;
      end
      S_WAIT: begin
        if (STAGE_READY_IN[idx_q]) begin
          if (idx_q == 2'd3) begin
            state_d     = S_DONE;
            all_ready_d = 1'b1;
          end else begin
            state_d = S_GAP;
            cnt_d   = 8'd0;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d       = S_FAULT;
          fault_d       = 1'b1;
          fault_stage_d = idx_q;
          stage_rst_d   = 4'hF;
          all_ready_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_RELEASE;
          idx_d   = idx_q + 2'd1;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        if (STAGE_READY_IN != 4'hF) begin
          state_d       = S_FAULT;
          fault_d       = 1'b1;
          fault_stage_d = low_idx;
          stage_rst_d   = 4'hF;
          all_ready_d   = 1'b0;
        end
      end
      S_FAULT: begin
        stage_rst_d = 4'hF;
        all_ready_d = 1'b0;
        fault_d     = 1'b1;
      end
      default: begin
        state_d     = S_HOLD;
        stage_rst_d = 4'hF;
        cnt_d       = 8'd0;
        idx_d       = 2'd0;
      end
    endcase

    // Soft restart overrides every transition above, including a coincident timeout.
    if (SOFT_RESET_IN) begin
      state_d       = S_HOLD;
      idx_d         = 2'd0;
      cnt_d         = 8'd0;
      stage_rst_d   = 4'hF;
      all_ready_d   = 1'b0;
      fault_d       = 1'b0;
      fault_stage_d = 2'd0;
    end
  end

  always_ff @(posedge CLK_IN or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q       <= S_HOLD;
      idx_q         <= 2'd0;
      cnt_q         <= 8'd0;
      stage_rst_q   <= 4'hF;
      all_ready_q   <= 1'b0;
      fault_q       <= 1'b0;
      fault_stage_q <= 2'd0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      stage_rst_q   <= stage_rst_d;
      all_ready_q   <= all_ready_d;
      fault_q       <= fault_d;
      fault_stage_q <= fault_stage_d;
    end
  end

  assign STAGE_RESET_OUT = stage_rst_q;
  assign ALL_READY_OUT   = all_ready_q;
  assign FAULT_OUT       = fault_q;
  assign FAULT_STAGE_OUT = fault_stage_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer at default parameters; edge numbers are
// counted from the first rising edge after RESET_IN (or a soft-reset pulse edge).
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_in;
  logic       soft_rst;
  logic [3:0] ready;
  logic [3:0] stage_rst;
  logic       all_ready;
  logic       fault;
  logic [1:0] fault_stage;
  logic [2:0] dbg_state;

  int total = 0;
  int bad   = 0;

  reset_sequencer dut (
    .CLK_IN          (clk),
    .RESET_IN        (rst_in),
    .SOFT_RESET_IN   (soft_rst),
    .STAGE_READY_IN  (ready),
    .STAGE_RESET_OUT (stage_rst),
    .ALL_READY_OUT   (all_ready),
    .FAULT_OUT       (fault),
    .FAULT_STAGE_OUT (fault_stage),
    .dbg_state_o     (dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // edge counter relative to the last release/pulse
  int edge_n = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance to absolute edge number n, sampling 1 ns after that edge
  task automatic to_edge(input int n);
    while (edge_n < n) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  // assert RESET_IN, check the reset outputs, release it between edges
  task automatic hard_reset(input string tag);
    @(posedge clk);
    #1;
    rst_in = 1'b0;
    #1;
    chk({tag, "_rst_stage"}, 32'(stage_rst), 32'hF);
    chk({tag, "_rst_allrdy"}, 32'(all_ready), 32'h0);
    chk({tag, "_rst_fault"}, 32'(fault), 32'h0);
    #3;
    rst_in = 1'b1;
    edge_n = 0;
  endtask

  task automatic soft_pulse;
    soft_rst = 1'b1;
    @(posedge clk);
    edge_n = 0;
    #1;
    soft_rst = 1'b0;
  endtask

  initial begin
    rst_in   = 1'b0;
    soft_rst = 1'b0;
    ready    = 4'hF;
    #22;
    chk("init_stage", 32'(stage_rst), 32'hF);
    chk("init_fault_stage", 32'(fault_stage), 32'h0);

    // Nominal sequence, ready tied high
    hard_reset("nom");
    to_edge(10); chk("nom_e10", 32'(stage_rst), 32'hF);
    to_edge(11); chk("nom_e11", 32'(stage_rst), 32'hE);
    to_edge(16); chk("nom_e16", 32'(stage_rst), 32'hE);
    to_edge(17); chk("nom_e17", 32'(stage_rst), 32'hC);
    to_edge(22); chk("nom_e22", 32'(stage_rst), 32'hC);
    to_edge(23); chk("nom_e23", 32'(stage_rst), 32'h8);
    to_edge(29); chk("nom_e29", 32'(stage_rst), 32'h0);
    chk("nom_e29_allrdy", 32'(all_ready), 32'h0);
    to_edge(30); chk("nom_e30_allrdy", 32'(all_ready), 32'h1);
    chk("nom_e30_fault", 32'(fault), 32'h0);

    // Ready loss in DONE
    to_edge(33);
    ready = 4'b1001;
    to_edge(34);
    chk("done_drop_fault", 32'(fault), 32'h1);
    chk("done_drop_idx", 32'(fault_stage), 32'h1);
    chk("done_drop_allrdy", 32'(all_ready), 32'h0);
    chk("done_drop_stage", 32'(stage_rst), 32'hF);
    to_edge(40);
    chk("fault_sticky", 32'(fault), 32'h1);

    // Soft restart out of FAULT
    ready = 4'hF;
    soft_pulse();
    chk("soft_fault_clr", 32'(fault), 32'h0);
    chk("soft_idx_clr", 32'(fault_stage), 32'h0);
    chk("soft_stage", 32'(stage_rst), 32'hF);
    to_edge(8); chk("soft_e8", 32'(stage_rst), 32'hF);
    to_edge(9); chk("soft_e9", 32'(stage_rst), 32'hE);

    // Stage 2 never ready -> timeout
    to_edge(12);
    ready = 4'b1011;
    hard_reset("to");
    to_edge(22); chk("to_e22", 32'(stage_rst), 32'hC);
    to_edge(23); chk("to_e23", 32'(stage_rst), 32'h8);
    to_edge(38); chk("to_e38_fault", 32'(fault), 32'h0);
    to_edge(39); chk("to_e39_fault", 32'(fault), 32'h1);
    chk("to_e39_idx", 32'(fault_stage), 32'h2);
    chk("to_e39_stage", 32'(stage_rst), 32'hF);

    // Soft reset coinciding with the timeout edge
    soft_pulse();
    to_edge(36);
    chk("coin_e36_fault", 32'(fault), 32'h0);
    chk("coin_e36_stage", 32'(stage_rst), 32'h8);
    soft_rst = 1'b1;
    to_edge(37);
    soft_rst = 1'b0;
    chk("coin_fault", 32'(fault), 32'h0);
    chk("coin_stage", 32'(stage_rst), 32'hF);
    to_edge(60);
    chk("coin_after_fault", 32'(fault), 32'h0);

    // 3 ns RESET_IN glitch during GAP after stage 1
    ready = 4'hF;
    hard_reset("gl");
    to_edge(19);
    chk("gl_gap_stage", 32'(stage_rst), 32'hC);
    rst_in = 1'b0;
    #1;
    chk("gl_async_stage", 32'(stage_rst), 32'hF);
    #2;
    rst_in = 1'b1;
    edge_n = 0;
    to_edge(10); chk("gl_e10", 32'(stage_rst), 32'hF);
    to_edge(11); chk("gl_e11", 32'(stage_rst), 32'hE);
    to_edge(30); chk("gl_e30_allrdy", 32'(all_ready), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
